fetch_buffer: RTL

Instruction queue between the instruction fetch stage and the decode stage. Each fetched beat (PC, PC+4, instruction word) is captured into a small FIFO so that decode backpressure does not force fetch to stall on the same cycle. A branch-taken flush discards everything queued. Decode always reads from the head entry.

---
 rtl/fetch_buffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer
//
// Instruction queue between fetch and decode. Each accepted fetch beat
// {pc, pc4, instr} is stored in a small circular FIFO so that decode
// backpressure does not stall fetch in the same cycle. A flush (branch taken)
// empties the queue. Decode always reads the head entry.
//
// Optional feature (compile-time macro): FETCH_BUFFER_BYPASS_EN
//   When defined and the queue is empty, an incoming beat is presented on the
//   outputs in the same cycle. If decode takes it, the beat is never written.
//
// Ports
//   clk        in   clock, rising edge
//   arst       in   asynchronous active-high reset
//   in_valid   in   fetch presents a beat
//   in_ready   out  buffer can accept a beat (registered state only)
//   in_pc      in   PC of incoming instruction
//   in_pc4     in   PC+4 of incoming instruction
//   in_instr   in   incoming instruction word
//   out_valid  out  head entry valid
//   out_ready  in   decode consumes the head
//   out_pc     out  head PC (0 when out_valid=0)
//   out_pc4    out  head PC+4 (0 when out_valid=0)
//   out_instr  out  head instruction (NOP_INSTR when out_valid=0)
//   flush      in   discard all entries; wins over push and pop
//   count      out  current occupancy
// ----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    input  logic [DATA_WIDTH-1:0]    in_pc4,
    input  logic [DATA_WIDTH-1:0]    in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_pc,
    output logic [DATA_WIDTH-1:0]    out_pc4,
    output logic [DATA_WIDTH-1:0]    out_instr,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] r_pc4   [DEPTH];
    logic [DATA_WIDTH-1:0] r_instr [DEPTH];

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

`ifdef FETCH_BUFFER_BYPASS_EN
    assign w_bypass = w_empty & in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed beat that decode takes directly is never stored.
    assign w_push = in_valid & ~w_full & ~flush & ~(w_bypass & out_ready);
    // Only a stored head can be popped; a bypassed beat is handled above.
    assign w_pop  = ~w_empty & out_ready & ~flush;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry contents need no reset: they are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wptr]    <= in_pc;
            r_pc4[r_wptr]   <= in_pc4;
            r_instr[r_wptr] <= in_instr;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_pc4   = '0;
        out_instr = NOP_INSTR;
        if (!w_empty) begin
            out_valid = 1'b1;
            out_pc    = r_pc[r_rptr];
            out_pc4   = r_pc4[r_rptr];
            out_instr = r_instr[r_rptr];
        end else if (w_bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_pc4   = in_pc4;
            out_instr = in_instr;
        end
    end

    assign in_ready = ~w_full;
    assign count    = r_count;

endmodule
